// File: rtl/dt_pkg.sv
// Shared definitions for the decision-tree walker: node-word field layout,
// field widths and the walker state encoding.
package dt_pkg;

  localparam int unsigned NODE_W       = 64;
  localparam int unsigned FEAT_W       = 32;

  // Node word layout; bits [12:8] are reserved.
  localparam int unsigned LEAF_W       = 1;
  localparam int unsigned LEAF_BIT     = 63;
  localparam int unsigned FEAT_IDX_LSB = 60;
  localparam int unsigned FEAT_IDX_W   = 3;
  localparam int unsigned THR_LSB      = 33;
  localparam int unsigned THR_W        = 27;
  localparam int unsigned LEFT_LSB     = 23;
  localparam int unsigned RIGHT_LSB    = 13;
  localparam int unsigned PTR_W        = 10;
  localparam int unsigned CLASS_LSB    = 0;
  localparam int unsigned CLASS_W      = 8;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StFetch   = 3'd1,
    StEval    = 3'd2,
    StCompare = 3'd3,
    StWaitCmp = 3'd4,
    StDone    = 3'd5
  } dt_state_e;

endpackage

// File: rtl/dt_feature_mux.sv
// Feature-select mux: picks feature[sel] from the latched feature vector and
// flags whether sel addresses an existing feature.
module dt_feature_mux
  import dt_pkg::*;
#(
  parameter int unsigned NUM_FEAT = 8
) (
  input  logic [FEAT_W*NUM_FEAT-1:0] features,
  input  logic [FEAT_IDX_W-1:0]      sel,
  output logic [FEAT_W-1:0]          feature,
  output logic                       sel_ok
);

  // Compare-and-select over the configured features; out-of-range sel gives 0.
  always_comb begin
    feature = '0;
    sel_ok  = 1'b0;
    for (int unsigned i = 0; i < NUM_FEAT; i++) begin
      if (sel == FEAT_IDX_W'(i)) begin
        feature = features[i*FEAT_W +: FEAT_W];
        sel_ok  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dt_tree_walker.sv
// Decision-tree walker: fetches nodes from an external node memory, hands
// feature/threshold pairs to an external comparator and follows the chosen
// child pointer until a leaf is reached.
// Optional feature: define DT_DEPTH_GUARD_EN to abort walks that traverse
// MAX_DEPTH internal nodes (loop protection).
module dt_tree_walker
  import dt_pkg::*;
#(
  parameter int unsigned NUM_FEAT  = 8,
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned MAX_DEPTH = 31
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [FEAT_W*NUM_FEAT-1:0] features,
  output logic                       busy,
  output logic                       node_rd,
  output logic [ADDR_W-1:0]          node_addr,
  input  logic [NODE_W-1:0]          node_rdata,
  output logic                       cmp_valid,
  output logic [FEAT_W-1:0]          cmp_feature,
  output logic [THR_W-1:0]           cmp_threshold,
  input  logic                       cmp_go_left,
  input  logic                       cmp_done,
  output logic                       result_valid,
  output logic [CLASS_W-1:0]         class_out,
  output logic                       error
);

  dt_state_e                  state_q, state_d;
  logic [FEAT_W*NUM_FEAT-1:0] features_q, features_d;
  logic [ADDR_W-1:0]          addr_q, addr_d;
  logic [FEAT_W-1:0]          feat_q, feat_d;
  logic [THR_W-1:0]           thr_q, thr_d;
  logic [PTR_W-1:0]           left_q, left_d;
  logic [PTR_W-1:0]           right_q, right_d;
  logic [CLASS_W-1:0]         class_q, class_d;
  logic                       error_q, error_d;

`ifdef DT_DEPTH_GUARD_EN
  localparam int unsigned DEPTH_W = $clog2(MAX_DEPTH + 1);
  logic [DEPTH_W-1:0] depth_q, depth_d;
`else
  localparam int unsigned unused_max_depth = MAX_DEPTH;
`endif

  // Node word fields, meaningful only while in StEval.
  logic                  nd_leaf;
  logic [FEAT_IDX_W-1:0] nd_feat_idx;
  logic [THR_W-1:0]      nd_thr;
  logic [PTR_W-1:0]      nd_left;
  logic [PTR_W-1:0]      nd_right;
  logic [CLASS_W-1:0]    nd_class;
  logic                  unused_rsvd;

  assign nd_leaf     = node_rdata[LEAF_BIT];
  assign nd_feat_idx = node_rdata[FEAT_IDX_LSB +: FEAT_IDX_W];
  assign nd_thr      = node_rdata[THR_LSB +: THR_W];
  assign nd_left     = node_rdata[LEFT_LSB +: PTR_W];
  assign nd_right    = node_rdata[RIGHT_LSB +: PTR_W];
  assign nd_class    = node_rdata[CLASS_LSB +: CLASS_W];
  assign unused_rsvd = ^node_rdata[RIGHT_LSB-1:CLASS_W];

  logic [FEAT_W-1:0] mux_feature;
  logic              mux_ok;

  dt_feature_mux #(
    .NUM_FEAT (NUM_FEAT)
  ) u_feature_mux (
    .features (features_q),
    .sel      (nd_feat_idx),
    .feature  (mux_feature),
    .sel_ok   (mux_ok)
  );

  // Next-state and datapath-update logic for the walk FSM.
  always_comb begin
    state_d    = state_q;
    features_d = features_q;
    addr_d     = addr_q;
    feat_d     = feat_q;
    thr_d      = thr_q;
    left_d     = left_q;
    right_d    = right_q;
    class_d    = class_q;
    error_d    = error_q;
`ifdef DT_DEPTH_GUARD_EN
    depth_d    = depth_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StFetch;
          features_d = features;
          addr_d     = '0;
`ifdef DT_DEPTH_GUARD_EN
          depth_d    = '0;
`endif
        end
      end
      StFetch: state_d = StEval;
      StEval: begin
        if (nd_leaf) begin
          class_d = nd_class;
          error_d = 1'b0;
          state_d = StDone;
        end else if (!mux_ok) begin
          class_d = '0;
          error_d = 1'b1;
          state_d = StDone;
        end else begin
          feat_d  = mux_feature;
          thr_d   = nd_thr;
          left_d  = nd_left;
          right_d = nd_right;
          state_d = StCompare;
        end
      end
      StCompare: state_d = StWaitCmp;
      StWaitCmp: begin
        if (cmp_done) begin
          addr_d = cmp_go_left ? ADDR_W'(left_q) : ADDR_W'(right_q);
`ifdef DT_DEPTH_GUARD_EN
          depth_d = depth_q + 1'b1;
          if (depth_d == DEPTH_W'(MAX_DEPTH)) begin
            class_d = '0;
            error_d = 1'b1;
            state_d = StDone;
          end else begin
            state_d = StFetch;
          end
`else
          state_d = StFetch;
`endif
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      features_q <= '0;
      addr_q     <= '0;
      feat_q     <= '0;
      thr_q      <= '0;
      left_q     <= '0;
      right_q    <= '0;
      class_q    <= '0;
      error_q    <= 1'b0;
`ifdef DT_DEPTH_GUARD_EN
      depth_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      features_q <= features_d;
      addr_q     <= addr_d;
      feat_q     <= feat_d;
      thr_q      <= thr_d;
      left_q     <= left_d;
      right_q    <= right_d;
      class_q    <= class_d;
      error_q    <= error_d;
`ifdef DT_DEPTH_GUARD_EN
      depth_q    <= depth_d;
`endif
    end
  end

  // Strobes are state decodes, so they are mutually exclusive by construction.
  always_comb begin
    busy          = (state_q != StIdle);
    node_rd       = (state_q == StFetch);
    cmp_valid     = (state_q == StCompare);
    result_valid  = (state_q == StDone);
    node_addr     = addr_q;
    cmp_feature   = feat_q;
    cmp_threshold = thr_q;
    class_out     = class_q;
    error         = error_q;
  end

endmodule

// File: tb/tb_dt_tree_walker.sv
// Self-checking bench for dt_tree_walker (NUM_FEAT=4): node memory and
// comparator models, table-driven walks plus hand-written corner sequences.
`timescale 1ns/1ps
module tb_dt_tree_walker;

  localparam int unsigned NF = 4;
  localparam int unsigned AW = 10;
  localparam int unsigned MD = 31;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [32*NF-1:0] features;
  logic            busy, node_rd;
  logic [AW-1:0]   node_addr;
  logic [63:0]     node_rdata;
  logic            cmp_valid;
  logic [31:0]     cmp_feature;
  logic [26:0]     cmp_threshold;
  logic            cmp_go_left = 1'b0;
  logic            cmp_done_r = 1'b0;
  logic            spur;
  logic            cmp_done;
  logic            result_valid;
  logic [7:0]      class_out;
  logic            error;

  always #5 clk = ~clk;

  dt_tree_walker #(
    .NUM_FEAT  (NF),
    .ADDR_W    (AW),
    .MAX_DEPTH (MD)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .features      (features),
    .busy          (busy),
    .node_rd       (node_rd),
    .node_addr     (node_addr),
    .node_rdata    (node_rdata),
    .cmp_valid     (cmp_valid),
    .cmp_feature   (cmp_feature),
    .cmp_threshold (cmp_threshold),
    .cmp_go_left   (cmp_go_left),
    .cmp_done      (cmp_done),
    .result_valid  (result_valid),
    .class_out     (class_out),
    .error         (error)
  );

  // Node memory: data valid one cycle after node_rd, junk otherwise.
  logic [63:0] mem [1024];
  always @(posedge clk) node_rdata <= node_rd ? mem[node_addr] : 64'hDEAD_BEEF_DEAD_BEEF;

  // Comparator: answers one cycle after cmp_valid; spur injects stray cmp_done.
  always @(posedge clk) begin
    cmp_done_r  <= cmp_valid;
    cmp_go_left <= cmp_valid && (cmp_feature <= {5'b0, cmp_threshold});
  end
  assign cmp_done = cmp_done_r | spur;

  typedef struct {
    string       name;
    int          lat;
    logic [7:0]  cls;
    logic        err;
    int          ncmp;
    logic [9:0]  last;
    logic [31:0] cfeat;
    logic [26:0] cthr;
  } exp_t;

  typedef struct {
    logic [63:0]  n0, n1, n2, n3;
    logic [127:0] feats;
    exp_t         e;
  } vec_t;

  int   nchecks = 0;
  int   nerrors = 0;
  exp_t sbq[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mk_node(input logic lf, input logic [2:0] fi,
                                          input logic [26:0] th, input logic [9:0] l,
                                          input logic [9:0] r, input logic [7:0] c);
    logic [63:0] w;
    w        = '0;
    w[63]    = lf;
    w[62:60] = fi;
    w[59:33] = th;
    w[32:23] = l;
    w[22:13] = r;
    w[12:8]  = 5'h15;
    w[7:0]   = c;
    return w;
  endfunction

  function automatic logic [127:0] mk_feats(input logic [31:0] f0, input logic [31:0] f1,
                                            input logic [31:0] f2, input logic [31:0] f3);
    return {f3, f2, f1, f0};
  endfunction

  function automatic vec_t mk_vec(input string name, input logic [63:0] n0,
                                  input logic [63:0] n1, input logic [63:0] n2,
                                  input logic [63:0] n3, input logic [127:0] feats,
                                  input int lat, input logic [7:0] cls, input logic err,
                                  input int ncmp, input logic [9:0] last,
                                  input logic [31:0] cfeat, input logic [26:0] cthr);
    vec_t v;
    v.n0 = n0; v.n1 = n1; v.n2 = n2; v.n3 = n3; v.feats = feats;
    v.e.name = name; v.e.lat = lat; v.e.cls = cls; v.e.err = err;
    v.e.ncmp = ncmp; v.e.last = last; v.e.cfeat = cfeat; v.e.cthr = cthr;
    return v;
  endfunction

  // Monitor: per-walk statistics and scoreboard pop on result_valid.
  int          cyc = 0;
  logic        busy_prev = 1'b0;
  int          acc_cyc = 0, n_cmp = 0, n_rd = 0, overlap = 0, results = 0;
  logic [9:0]  first_addr = '0, last_addr = '0;
  logic [31:0] first_cf = '0;
  logic [26:0] first_ct = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      busy_prev = 1'b0;
    end else begin
      if (busy && !busy_prev) begin
        acc_cyc = cyc;
        n_cmp   = 0;
        n_rd    = 0;
      end
      busy_prev = busy;
      if ($countones({node_rd, cmp_valid, result_valid}) > 1) overlap++;
      if (node_rd) begin
        if (n_rd == 0) first_addr = node_addr;
        last_addr = node_addr;
        n_rd++;
      end
      if (cmp_valid) begin
        if (n_cmp == 0) begin
          first_cf = cmp_feature;
          first_ct = cmp_threshold;
        end
        n_cmp++;
      end
      if (result_valid) begin
        results++;
        if (sbq.size() == 0) begin
          check("unexpected_result_valid", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          check({e.name, ".latency"}, 64'(cyc - acc_cyc + 1), 64'(e.lat));
          check({e.name, ".class"}, 64'(class_out), 64'(e.cls));
          check({e.name, ".error"}, 64'(error), 64'(e.err));
          check({e.name, ".compares"}, 64'(n_cmp), 64'(e.ncmp));
          check({e.name, ".root_addr"}, 64'(first_addr), 64'd0);
          check({e.name, ".last_addr"}, 64'(last_addr), 64'(e.last));
          if (e.ncmp > 0) begin
            check({e.name, ".cmp_feature"}, 64'(first_cf), 64'(e.cfeat));
            check({e.name, ".cmp_threshold"}, 64'(first_ct), 64'(e.cthr));
          end
        end
      end
    end
  end

  task automatic load(input vec_t v);
    mem[0] = v.n0; mem[1] = v.n1; mem[2] = v.n2; mem[3] = v.n3;
    features = v.feats;
  endtask

  // Start a walk (start high for one edge) and queue its expectation.
  task automatic launch(input vec_t v);
    load(v);
    @(negedge clk);
    start = 1'b1;
    sbq.push_back(v.e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_results(input int tgt, input int budget, input string name);
    int k = 0;
    while (results < tgt && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (results < tgt) begin
      check({name, ".timeout"}, 64'(results), 64'(tgt));
      sbq.delete();
    end
  endtask

  task automatic wait_rv(input int budget, input string name);
    int k = 0;
    while (!result_valid && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (!result_valid) check({name, ".rv_timeout"}, 64'd0, 64'd1);
  endtask

  vec_t        vt[10];
  logic [63:0] lf1, lf2, t1_root, sloop;
  vec_t        v;
  int          tgt;
  int          seen;
  int          want_cmp;

  initial begin
    rst = 1'b1; start = 1'b0; spur = 1'b0; features = '0;
    for (int i = 0; i < 1024; i++) mem[i] = '0;

    lf1     = mk_node(1'b1, 3'd0, 27'd0, 10'd0, 10'd0, 8'h0A);
    lf2     = mk_node(1'b1, 3'd0, 27'd0, 10'd0, 10'd0, 8'h3C);
    t1_root = mk_node(1'b0, 3'd2, 27'd100, 10'd1, 10'd2, 8'h00);
    sloop   = mk_node(1'b0, 3'd1, 27'd10, 10'd0, 10'd0, 8'h77);

    vt[0] = mk_vec("root_leaf", mk_node(1'b1, 3'd5, 27'd9, 10'd7, 10'd8, 8'h05), lf1, lf2, '0,
                   mk_feats(1000, 2000, 100, 0), 3, 8'h05, 1'b0, 0, 10'd0, '0, '0);
    vt[1] = mk_vec("left_equal", t1_root, lf1, lf2, '0, mk_feats(1000, 2000, 100, 0),
                   7, 8'h0A, 1'b0, 1, 10'd1, 32'd100, 27'd100);
    vt[2] = mk_vec("right_plus1", t1_root, lf1, lf2, '0, mk_feats(1000, 2000, 101, 0),
                   7, 8'h3C, 1'b0, 1, 10'd2, 32'd101, 27'd100);
    vt[3] = mk_vec("left_zero", t1_root, lf1, lf2, '0, mk_feats(1000, 2000, 0, 5000),
                   7, 8'h0A, 1'b0, 1, 10'd1, 32'd0, 27'd100);
    vt[4] = mk_vec("bad_idx7", mk_node(1'b0, 3'd7, 27'd5, 10'd1, 10'd2, 8'h55), lf1, lf2, '0,
                   mk_feats(1, 2, 3, 4), 3, 8'h00, 1'b1, 0, 10'd0, '0, '0);
    vt[5] = mk_vec("bad_idx4", mk_node(1'b0, 3'd4, 27'd5, 10'd1, 10'd2, 8'h55), lf1, lf2, '0,
                   mk_feats(1, 2, 3, 4), 3, 8'h00, 1'b1, 0, 10'd0, '0, '0);
    vt[6] = mk_vec("idx3_maxthr_left", mk_node(1'b0, 3'd3, 27'h7FF_FFFF, 10'd1, 10'd2, 8'h00),
                   lf1, lf2, '0, mk_feats(32'hFFFF_FFFF, 0, 0, 32'h07FF_FFFF),
                   7, 8'h0A, 1'b0, 1, 10'd1, 32'h07FF_FFFF, 27'h7FF_FFFF);
    vt[7] = mk_vec("idx3_wide_right", mk_node(1'b0, 3'd3, 27'h7FF_FFFF, 10'd1, 10'd2, 8'h00),
                   lf1, lf2, '0, mk_feats(0, 0, 0, 32'h0800_0000),
                   7, 8'h3C, 1'b0, 1, 10'd2, 32'h0800_0000, 27'h7FF_FFFF);
    vt[8] = mk_vec("depth2", mk_node(1'b0, 3'd0, 27'd50, 10'd3, 10'd2, 8'h00), lf1, lf2,
                   mk_node(1'b0, 3'd1, 27'd10, 10'd1, 10'd2, 8'h00), mk_feats(50, 11, 0, 0),
                   11, 8'h3C, 1'b0, 2, 10'd2, 32'd50, 27'd50);
    vt[9] = mk_vec("depth2_early_right", mk_node(1'b0, 3'd0, 27'd50, 10'd3, 10'd2, 8'h00),
                   lf1, lf2, mk_node(1'b0, 3'd1, 27'd10, 10'd1, 10'd2, 8'h00),
                   mk_feats(51, 0, 0, 0), 7, 8'h3C, 1'b0, 1, 10'd2, 32'd51, 27'd50);

    // Reset state
    #1;
    check("rst.busy", 64'(busy), 0);
    check("rst.node_rd", 64'(node_rd), 0);
    check("rst.cmp_valid", 64'(cmp_valid), 0);
    check("rst.result_valid", 64'(result_valid), 0);
    check("rst.error", 64'(error), 0);
    check("rst.data", {node_addr, cmp_threshold, class_out}, 0);
    check("rst.cmp_feature", 64'(cmp_feature), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Table-driven walks
    for (int i = 0; i < 10; i++) begin
      tgt = results + 1;
      launch(vt[i]);
      wait_results(tgt, 200, vt[i].e.name);
      repeat (2) @(negedge clk);
    end

    // Start and feature changes mid-walk are ignored
    tgt = results + 1;
    launch(vt[1]);
    repeat (2) @(negedge clk);
    features = mk_feats(1000, 2000, 101, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_results(tgt, 200, "midwalk_start");
    repeat (6) @(negedge clk);
    check("midwalk.no_second_walk", 64'(busy), 0);
    check("midwalk.class_hold", 64'(class_out), 64'h0A);

    // start during DONE ignored, accepted in the following IDLE
    v = vt[0];
    v.e.name = "done_restart";
    launch(vt[2]);
    wait_rv(200, "done_a");
    load(v);
    start = 1'b1;
    @(negedge clk);
    check("done.start_ignored", 64'(busy), 0);
    sbq.push_back(v.e);
    tgt = results + 1;
    @(negedge clk);
    start = 1'b0;
    check("idle.start_accepted", 64'(busy), 1);
    wait_results(tgt, 200, "done_restart");
    repeat (2) @(negedge clk);

    // Stray cmp_done outside WAIT_CMP is ignored
    tgt = results + 1;
    v = vt[1];
    v.e.name = "stray_cmp_done";
    launch(v);
    spur = 1'b1;
    repeat (3) @(negedge clk);
    spur = 1'b0;
    wait_results(tgt, 200, "stray_cmp_done");
    repeat (2) @(negedge clk);

`ifdef DT_DEPTH_GUARD_EN
    // Self-looping node trips the depth guard
    tgt = results + 1;
    launch(mk_vec("depth_guard", sloop, lf1, lf2, '0, mk_feats(0, 5, 0, 0),
                  4 * MD + 1, 8'h00, 1'b1, MD, 10'd0, 32'd5, 27'd10));
    wait_results(tgt, 400, "depth_guard");
    repeat (2) @(negedge clk);
    want_cmp = 10;
`else
    want_cmp = 40;
`endif

    // Self loop, then reset while in WAIT_CMP
    mem[0] = sloop;
    features = mk_feats(0, 5, 0, 0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    for (int k = 0; k < 400 && seen < want_cmp; k++) begin
      @(negedge clk);
      if (cmp_valid) seen++;
    end
    check("loop.compares_reached", 64'(seen), 64'(want_cmp));
    check("loop.still_busy", 64'(busy), 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst.busy", 64'(busy), 0);
    check("midrst.strobes", {node_rd, cmp_valid, result_valid, error}, 0);
    check("midrst.data", {node_addr, cmp_threshold, class_out}, 0);
    check("midrst.cmp_feature", 64'(cmp_feature), 0);
    @(negedge clk);
    rst = 1'b0;
    v = vt[0];
    v.e.name = "after_reset";
    load(v);
    start = 1'b1;
    sbq.push_back(v.e);
    tgt = results + 1;
    @(negedge clk);
    start = 1'b0;
    check("after_reset.accepted", 64'(busy), 1);
    wait_results(tgt, 200, "after_reset");
    repeat (4) @(negedge clk);

    check("strobe_overlap", 64'(overlap), 0);
    check("scoreboard_empty", 64'(sbq.size()), 0);

    $display("CHECKS %0d ERRORS %0d", nchecks, nerrors);
    $finish;
  end

endmodule

// File: doc/dt_tree_walker.md
DT_TREE_WALKER -- requirements
Module: dt_tree_walker

Interface
REQ-001 The module SHALL have a parameter NUM_FEAT, default 8, giving the number of 32-bit features per sample (power of 2, max 8).
REQ-002 The module SHALL have a parameter ADDR_W, default 10, giving the node-memory address width.
REQ-003 The module SHALL have a parameter MAX_DEPTH, default 31, giving the largest allowed count of internal nodes per walk.
REQ-004 clk  in  1  single clock; all logic rising-edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 start  in  1  begin a walk; accepted only in IDLE.
REQ-007 features  in  32*NUM_FEAT  feature vector, feature i at bits [32i+31:32i]; latched when start is accepted.
REQ-008 busy  out  1  high in every state except IDLE.
REQ-009 node_rd  out  1  node-memory read strobe.
REQ-010 node_addr  out  ADDR_W  read address.
REQ-011 node_rdata  in  64  node word, valid exactly 1 cycle after node_rd.
REQ-012 cmp_valid  out  1  one-cycle request to the threshold comparator.
REQ-013 cmp_feature  out  32  selected feature value.
REQ-014 cmp_threshold  out  27  node threshold.
REQ-015 cmp_go_left  in  1  comparator decision (feature <= threshold).
REQ-016 cmp_done  in  1  comparator result valid, 1 cycle after cmp_valid.
REQ-017 result_valid  out  1  one-cycle pulse when a walk ends.
REQ-018 class_out  out  8  leaf class; holds its value until the next result_valid.
REQ-019 error  out  1  qualifies result_valid; high means the walk was aborted.

Function
REQ-020 The node word SHALL be laid out as: [63] leaf; [62:60] feat_idx; [59:33] threshold; [32:23] left ptr; [22:13] right ptr; [7:0] class. Bits [12:8] are reserved and ignored.
REQ-021 The FSM SHALL have the states IDLE, FETCH, EVAL, COMPARE, WAIT_CMP, DONE.
REQ-022 IDLE -> FETCH on start; the FSM SHALL latch features and set the current address to 0 (root) and the depth count to 0.
REQ-023 FETCH SHALL assert node_rd for exactly 1 cycle with node_addr = current address, then go to EVAL.
REQ-024 EVAL, leaf=1: the FSM SHALL capture class and go to DONE with error=0.
REQ-025 EVAL, leaf=0: the FSM SHALL register feature[feat_idx], threshold, left ptr and right ptr, then go to COMPARE.
REQ-026 EVAL, leaf=0 with feat_idx >= NUM_FEAT: the FSM SHALL go to DONE with error=1 and class_out=0.
REQ-027 COMPARE SHALL assert cmp_valid for exactly 1 cycle, then go to WAIT_CMP.
REQ-028 WAIT_CMP SHALL wait for cmp_done, then set address = left ptr if cmp_go_left else right ptr, increment depth, and go to FETCH.
REQ-029 DONE SHALL pulse result_valid for 1 cycle, then go to IDLE.
REQ-030 Latency: result_valid SHALL occur 3 + 4*D cycles after the start-accept edge, D = internal nodes traversed.
REQ-031 The FSM SHALL ignore start while busy; features SHALL stay unchanged mid-walk.
REQ-032 The FSM SHALL ignore cmp_done outside WAIT_CMP.
REQ-033 start asserted in the same cycle as the DONE pulse SHALL be ignored; the earliest new start is accepted in the following IDLE cycle.
REQ-034 node_rd, cmp_valid and result_valid SHALL never be high in the same cycle.

Reset
REQ-035 While rst is high, asynchronously: state=IDLE; busy, node_rd, cmp_valid, result_valid and error SHALL be 0; node_addr, cmp_feature, cmp_threshold and class_out SHALL be 0.
REQ-036 Reset mid-walk SHALL abort the walk with no result_valid; the walker SHALL accept start on the first cycle after rst is released.

Configuration
REQ-037 With DT_DEPTH_GUARD_EN defined: if the depth count reaches MAX_DEPTH when WAIT_CMP completes, the FSM SHALL go to DONE with error=1 instead of FETCH (loop protection).
REQ-038 Without DT_DEPTH_GUARD_EN: there SHALL be no depth limit; the depth counter MAY be removed; error SHALL come only from REQ-026.

Structure
REQ-039 A shared package dt_pkg SHALL hold the node-word field positions and widths, the state encoding, and the LEAF and CLASS widths.
REQ-040 The feature-select mux SHALL be the sub-module dt_feature_mux; the FSM and datapath SHALL stay in dt_tree_walker.

Verification
REQ-041 Root leaf, class 0x05: start -> node_rd at addr 0; result_valid 3 cycles after accept, class_out=0x05, error=0.
REQ-042 Root internal (feat 2, threshold 100), feature2=100, left leaf at addr 1 = class 0x0A -> cmp_threshold=100, cmp_feature=100, go_left=1; fetch addr 1; result_valid 7 cycles after accept, class_out=0x0A.
REQ-043 Same tree, feature2=101 -> right ptr 2 fetched; class_out = class of node 2; latency 7 cycles.
REQ-044 Root has feat_idx=7 with NUM_FEAT=4 -> no cmp_valid; result_valid at cycle 3, error=1, class_out=0.
REQ-045 Node 0 points to itself, DT_DEPTH_GUARD_EN defined, MAX_DEPTH=31 -> result_valid with error=1 after 31 compares. Also: start pulsed mid-walk is ignored, and rst asserted during WAIT_CMP gives busy=0 immediately with no result_valid.
